// File: rtl/seq_shifter.sv
// seq_shifter
// Multi-cycle shift/rotate unit that moves the operand one bit position per
// clock. An accepted request loads the operand and then steps it Amt times,
// raising done for one cycle when the final step lands (or right away when
// Amt is zero).
//
// Parameters:
//   WIDTH  data width in bits (>= 2)
//   CNT_W  width of the shift-amount input
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    synchronous reset, active-high
//   start  request, sampled only while not busy
//   A      operand
//   Mode   operation select
//   Amt    number of single-bit steps
//   R      result register
//   C      last bit shifted or rotated out
//   busy   operation in progress
//   done   one-cycle completion pulse
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       Mode,
  input  logic [CNT_W-1:0] Amt,
  output logic [WIDTH-1:0] R,
  output logic             C,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_SHL0 = 3'b000;
  localparam logic [2:0] MODE_SHL1 = 3'b001;
  localparam logic [2:0] MODE_SHR0 = 3'b010;
  localparam logic [2:0] MODE_SHR1 = 3'b011;
  localparam logic [2:0] MODE_ASL  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_ROR  = 3'b111;

  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] step_r;
  logic             step_c;

  // One single-bit step of the latched operation applied to the current R.
  // Left operations lose R[WIDTH-1]; right operations lose R[0].
  always_comb begin
    step_r = R;
    step_c = 1'b0;
    case (mode_q)
      MODE_SHL0, MODE_ASL: begin
        step_r = {R[WIDTH-2:0], 1'b0};
        step_c = R[WIDTH-1];
      end
      MODE_SHL1: begin
        step_r = {R[WIDTH-2:0], 1'b1};
        step_c = R[WIDTH-1];
      end
      MODE_SHR0: begin
        step_r = {1'b0, R[WIDTH-1:1]};
        step_c = R[0];
      end
      MODE_SHR1: begin
        step_r = {1'b1, R[WIDTH-1:1]};
        step_c = R[0];
      end
      MODE_ASR: begin
        step_r = {R[WIDTH-1], R[WIDTH-1:1]};
        step_c = R[0];
      end
      MODE_ROL: begin
        step_r = {R[WIDTH-2:0], R[WIDTH-1]};
        step_c = R[WIDTH-1];
      end
      MODE_ROR: begin
        step_r = {R[0], R[WIDTH-1:1]};
        step_c = R[0];
      end
      default: begin
        step_r = R;
        step_c = 1'b0;
      end
    endcase
  end

  // Request acceptance, stepping and completion. done defaults low so it
  // only ever lasts a single cycle. A request arriving while busy falls
  // through untouched, which is what drops it. Because done and busy are
  // never high together, a start on the done cycle is accepted directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      R      <= '0;
      C      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mode_q <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        R   <= step_r;
        C   <= step_c;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        R      <= A;
        C      <= 1'b0;
        mode_q <= Mode;
        cnt    <= Amt;
        if (Amt != '0) begin
          busy <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter
// Self-checking bench for seq_shifter (WIDTH=8, CNT_W=3). Results are
// predicted with a closed-form reference that works out where each result
// bit and the carry came from after n steps, then compared every cycle of
// every operation.
module tb_seq_shifter;

  localparam int W     = 8;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     A;
  logic [2:0]       Mode;
  logic [CNT_W-1:0] Amt;
  logic [W-1:0]     R;
  logic             C;
  logic             busy;
  logic             done;

  int assertCount;
  int failCount;

  logic [W-1:0] lastR;
  logic         lastC;

  seq_shifter #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .Mode  (Mode),
    .Amt   (Amt),
    .R     (R),
    .C     (C),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Result of n steps of an operation on a, found by tracing each output bit
  // back to its source position in a (or to the fill value once the source
  // falls off the end). The carry is the source of the bit lost on step n.
  task automatic modelShift(input logic [W-1:0] a, input logic [2:0] mode,
                            input int n, output logic [W-1:0] r,
                            output logic c);
    logic fill;
    bit   isLeft;
    bit   isRot;
    int   src;
    isLeft = (mode == 3'b000) || (mode == 3'b001) || (mode == 3'b100) ||
             (mode == 3'b110);
    isRot  = (mode == 3'b110) || (mode == 3'b111);
    case (mode)
      3'b001, 3'b011: fill = 1'b1;
      3'b101:         fill = a[W-1];
      default:        fill = 1'b0;
    endcase
    for (int i = 0; i < W; i++) begin
      if (isRot) begin
        src  = isLeft ? ((((i - n) % W) + W) % W) : ((i + n) % W);
        r[i] = a[src];
      end else if (isLeft) begin
        src  = i - n;
        r[i] = (src >= 0) ? a[src] : fill;
      end else begin
        src  = i + n;
        r[i] = (src < W) ? a[src] : fill;
      end
    end
    if (n == 0) begin
      c = 1'b0;
    end else if (isRot) begin
      src = isLeft ? ((((W - n) % W) + W) % W) : ((n - 1) % W);
      c   = a[src];
    end else if (isLeft) begin
      src = W - n;
      c   = (src >= 0) ? a[src] : fill;
    end else begin
      src = n - 1;
      c   = (src < W) ? a[src] : fill;
    end
  endtask

  // Issues one request and follows it cycle by cycle to its done cycle.
  // Entered and left #1 after a rising edge, so a follow-up call starts on
  // the done cycle. injectEdge > 0 pulses a competing start at that edge;
  // rstEdge > 0 asserts reset at that edge and ends the operation there.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [2:0] mode,
                               input int amt, input int injectEdge,
                               input int rstEdge);
    logic [W-1:0] er;
    logic         ec;
    start = 1'b1;
    A     = a;
    Mode  = mode;
    Amt   = CNT_W'(amt);
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = W'($urandom);
    Mode  = 3'($urandom);
    Amt   = CNT_W'($urandom);
    checkOutput("accept_R", 32'(R), 32'(a));
    checkOutput("accept_C", 32'(C), 32'(0));
    checkOutput("accept_busy", 32'(busy), 32'(amt != 0));
    checkOutput("accept_done", 32'(done), 32'(amt == 0));
    lastR = a;
    lastC = 1'b0;
    for (int k = 1; k <= amt; k++) begin
      if (k == injectEdge) begin
        start = 1'b1;
        A     = '0;
        Amt   = CNT_W'(1);
      end
      if (k == rstEdge) rst = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = W'($urandom);
      Mode  = 3'($urandom);
      if (k == rstEdge) begin
        rst = 1'b0;
        checkOutput("rst_R", 32'(R), 32'(0));
        checkOutput("rst_C", 32'(C), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_done", 32'(done), 32'(0));
        lastR = '0;
        lastC = 1'b0;
        return;
      end
      modelShift(a, mode, k, er, ec);
      checkOutput("step_R", 32'(R), 32'(er));
      checkOutput("step_C", 32'(C), 32'(ec));
      checkOutput("step_busy", 32'(busy), 32'(k < amt));
      checkOutput("step_done", 32'(done), 32'(k == amt));
      lastR = er;
      lastC = ec;
    end
  endtask

  // Idle cycles with no request: done must stay low and R/C must hold.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      A     = W'($urandom);
      @(posedge clk);
      #1;
      checkOutput("idle_done", 32'(done), 32'(0));
      checkOutput("idle_busy", 32'(busy), 32'(0));
      checkOutput("idle_R", 32'(R), 32'(lastR));
      checkOutput("idle_C", 32'(C), 32'(lastC));
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    lastR       = '0;
    lastC       = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    A           = '0;
    Mode        = '0;
    Amt         = '0;
    $display("[TB] starting seq_shifter bench");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_R", 32'(R), 32'(0));
    checkOutput("reset_C", 32'(C), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    rst = 1'b0;
    idleCycles(1);

    // Arithmetic shift right keeps replicating the sign bit.
    applyStimulus(8'h96, 3'b101, 3, 0, 0);
    checkOutput("asr_R", 32'(R), 32'h0F2);
    checkOutput("asr_C", 32'(C), 32'h1);
    idleCycles(1);

    // Rotate left by half the width swaps nibbles.
    applyStimulus(8'hA5, 3'b110, 4, 0, 0);
    checkOutput("rol_R", 32'(R), 32'h05A);
    checkOutput("rol_C", 32'(C), 32'h0);
    idleCycles(1);

    // Fill-1 left shift, then a back-to-back request on the done cycle.
    applyStimulus(8'h00, 3'b001, 7, 0, 0);
    checkOutput("shl1_R", 32'(R), 32'h07F);
    checkOutput("shl1_C", 32'(C), 32'h0);
    applyStimulus(8'h81, 3'b010, 1, 0, 0);
    checkOutput("b2b_R", 32'(R), 32'h040);
    checkOutput("b2b_C", 32'(C), 32'h1);
    idleCycles(1);

    // Zero amount completes immediately without raising busy.
    applyStimulus(8'h3C, 3'($urandom), 0, 0, 0);
    checkOutput("amt0_R", 32'(R), 32'h03C);
    checkOutput("amt0_C", 32'(C), 32'h0);
    idleCycles(2);

    // A start pulse while busy is dropped, not queued.
    applyStimulus(8'hFF, 3'b010, 5, 2, 0);
    checkOutput("ignore_R", 32'(R), 32'h007);
    idleCycles(3);

    // Reset mid-operation, then a normal operation afterwards.
    applyStimulus(8'($urandom), 3'b111, 6, 0, 2);
    idleCycles(3);
    applyStimulus(8'hC3, 3'b111, 6, 0, 0);
    checkOutput("after_rst_R", 32'(R), 32'h00F);
    idleCycles(1);

    // Randomized operations with random gaps (sometimes back-to-back).
    for (int t = 0; t < 60; t++) begin
      applyStimulus(8'($urandom), 3'($urandom), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), 0);
      if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
